uart_send_fifo: RTL

Parametrised UART transmitter with a small input FIFO and a four-phase req/ack handshake. Producers push words at handshake speed, independent of line rate. Frames leave the TX pin back-to-back with no idle gap while the FIFO holds data. Data width, parity, stop-bit count, baud divider and FIFO depth are all configurable. It sits between any on-chip producer (CPU port, debug streamer) and the board UART pin, and is the general replacement for the fixed 8N1 single-byte sender.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_send_fifo_if.sv | 11 +
 rtl/uart_tx_fifo.sv | 60 ++++++
 rtl/uart_send_fifo.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART encodings: parity modes and transmit FSM states.
// Kept separate so the receiver can reuse the same encodings.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  // xor_all is the XOR reduction of the data word.
  function automatic logic parity_bit(input logic xor_all, input int unsigned mode);
    return (mode == PARITY_ODD) ? ~xor_all : xor_all;
  endfunction

endpackage

// File: rtl/uart_send_fifo_if.sv
// Four-phase req/ack push port of the UART send FIFO.
interface uart_send_fifo_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 uart_send_req;
  logic                 uart_send_ack;
  logic [DATA_BITS-1:0] uart_data_in;

  modport master (output uart_send_req, output uart_data_in, input uart_send_ack);
  modport slave  (input uart_send_req, input uart_data_in, output uart_send_ack);
endinterface

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO; read data is the combinational head entry.
module uart_tx_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  always_comb begin
    do_push = push_i & ~full_o;
    do_pop  = pop_i & ~empty_o;
    wptr_d  = do_push ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d  = do_pop ? rptr_q + PtrW'(1) : rptr_q;
    cnt_d   = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!do_push && do_pop) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/uart_send_fifo.sv
// UART transmitter fed by a small FIFO through a four-phase req/ack handshake.
// Frames are sent back-to-back while the FIFO holds data.
module uart_send_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 25,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  uart_send_fifo_if.slave  send,
  output logic             uart_txd,
  output logic             tx_busy,
  output logic             fifo_full
);
  localparam int unsigned DivW = $clog2(CLK_DIV);
  localparam int unsigned BitW = $clog2(DATA_BITS + 1);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  tx_state_e            state_q, state_d;
  logic [DivW-1:0]      div_q, div_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;
  logic                 req_meta_q, req_s_q;
  logic                 ack_q, ack_d;
  logic                 push, pop, load, bit_end;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic [CntW-1:0]      fifo_count;

  uart_tx_fifo #(
    .Width (DATA_BITS),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .push_i    (push),
    .wdata_i   (send.uart_data_in),
    .pop_i     (pop),
    .rdata_o   (fifo_rdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  // fifo_full is the pre-edge value, so a same-cycle pop never frees room for this push.
  assign push    = req_s_q & ~ack_q & ~fifo_full;
  assign bit_end = (div_q == DivW'(CLK_DIV - 1));

  always_comb begin
    ack_d = ack_q;
    if (push) begin
      ack_d = 1'b1;
    end else if (!req_s_q) begin
      ack_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    load    = 1'b0;
    if (state_q != StIdle) begin
      div_d = bit_end ? '0 : div_q + DivW'(1);
    end
    unique case (state_q)
      StIdle:  load = ~fifo_empty;
      StStart: if (bit_end) state_d = StData;
      StData: begin
        if (bit_end) begin
          if (bit_q == BitW'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != PARITY_NONE) ? StParity : StStop;
          end else begin
            bit_d = bit_q + BitW'(1);
            sh_d  = sh_q >> 1;
          end
        end
      end
      StParity: if (bit_end) state_d = StStop;
      StStop: begin
        if (bit_end) begin
          if (bit_q == BitW'(STOP_BITS - 1)) begin
            bit_d   = '0;
            load    = ~fifo_empty;
            state_d = StIdle;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
    pop = load;
    if (load) begin
      state_d = StStart;
      div_d   = '0;
      sh_d    = fifo_rdata;
      par_d   = parity_bit(^fifo_rdata, PARITY);
    end
    // Line value tracks the next state so the popping edge already drives the start bit.
    unique case (state_d)
      StStart:  txd_d = 1'b0;
      StData:   txd_d = sh_d[0];
      StParity: txd_d = par_q;
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= StIdle;
      div_q      <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      par_q      <= 1'b0;
      txd_q      <= 1'b1;
      req_meta_q <= 1'b0;
      req_s_q    <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      par_q      <= par_d;
      txd_q      <= txd_d;
      req_meta_q <= send.uart_send_req;
      req_s_q    <= req_meta_q;
      ack_q      <= ack_d;
    end
  end

  assign uart_txd           = txd_q;
  assign send.uart_send_ack = ack_q;
  assign tx_busy            = (state_q != StIdle) | (fifo_count != '0);

endmodule
